// File: rtl/ssio_align_pkg.sv
// ssio_align_pkg: shared state encoding and window-centre helper for the SDR input alignment sequencer
package ssio_align_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SETTLE,
        ST_SAMPLE,
        ST_EVAL,
        ST_CENTER,
        ST_NEXT,
        ST_DONE
    } align_state_t;

    localparam int ALIGN_MAX_TW = 16;

    // Centre of a window of len taps starting at start_tap; callers only use it with len > 0
    function automatic logic [ALIGN_MAX_TW:0] align_centre(
        input logic [ALIGN_MAX_TW:0] start_tap,
        input logic [ALIGN_MAX_TW:0] len
    );
        return start_tap + ((len - 1'b1) >> 1);
    endfunction

endpackage

// File: rtl/ssio_align_window_tracker.sv
// ssio_align_window_tracker: tracks the current and longest run of passing taps and its centre
module ssio_align_window_tracker
    import ssio_align_pkg::*;
#(
    parameter int TAP_WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [TAP_WIDTH-1:0] tap,
    input  logic                 pass,
    input  logic                 fail,
    input  logic                 clear,
    output logic [TAP_WIDTH-1:0] centre,
    output logic                 valid
);

    logic [TAP_WIDTH-1:0] run_start, run_start_n, best_start, best_start_n;
    logic [TAP_WIDTH:0]   run_len, run_len_n, best_len, best_len_n;

    // Next window state; centre/valid describe the window as it stands after this cycle's update
    always_comb begin
        run_start_n  = run_start;
        run_len_n    = run_len;
        best_start_n = best_start;
        best_len_n   = best_len;
        if (clear) begin
            run_start_n  = '0;
            run_len_n    = '0;
            best_start_n = '0;
            best_len_n   = '0;
        end else if (pass) begin
            run_start_n = (run_len == '0) ? tap : run_start;
            run_len_n   = run_len + 1'b1;
            if (run_len_n > best_len) begin
                best_start_n = run_start_n;
                best_len_n   = run_len_n;
            end
        end else if (fail) begin
            run_len_n = '0;
        end
    end

    assign centre = TAP_WIDTH'(align_centre((ALIGN_MAX_TW+1)'(best_start_n), (ALIGN_MAX_TW+1)'(best_len_n)));
    assign valid  = best_len_n != '0;

    // Window registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_start  <= '0;
            run_len    <= '0;
            best_start <= '0;
            best_len   <= '0;
        end else begin
            run_start  <= run_start_n;
            run_len    <= run_len_n;
            best_start <= best_start_n;
            best_len   <= best_len_n;
        end
    end

endmodule

// File: rtl/ssio_sdr_in_align_ctrl.sv
// ssio_sdr_in_align_ctrl: per-lane delay-tap sweep and centring; SSIO_ALIGN_LOCK_MON_EN adds a post-training lock monitor
module ssio_sdr_in_align_ctrl
    import ssio_align_pkg::*;
#(
    parameter int WIDTH         = 1,
    parameter int TAP_WIDTH     = 5,
    parameter int SETTLE_CYCLES = 16,
    parameter int SAMPLE_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     data_in,
    output logic [TAP_WIDTH-1:0] dly_tap,
    output logic [WIDTH-1:0]     dly_ld,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     lane_err,
    output logic                 lock_lost
);

    localparam int LW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    align_state_t         state;
    logic [LW-1:0]        lane;
    logic [TAP_WIDTH-1:0] tap;
    logic [31:0]          cnt;
    logic                 prev, fail_r, cur_bit, accept, trk_valid;
    logic [WIDTH-1:0]     lane_1h, nxt_1h;
    logic [TAP_WIDTH-1:0] trk_centre;

    assign cur_bit = data_in[lane];
    assign lane_1h = WIDTH'(1) << lane;
    assign nxt_1h  = WIDTH'(1) << (lane + 1'b1);
    assign accept  = start && (state == ST_IDLE || state == ST_DONE);

    ssio_align_window_tracker #(.TAP_WIDTH(TAP_WIDTH)) u_trk (
        .clk    (clk),
        .rst_n  (rst_n),
        .tap    (tap),
        .pass   (state == ST_EVAL && !fail_r),
        .fail   (state == ST_EVAL && fail_r),
        .clear  (accept || state == ST_NEXT),
        .centre (trk_centre),
        .valid  (trk_valid)
    );

    // Training sequencer; load strobes are registered so they land in the LOAD/CENTER cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            lane     <= '0;
            tap      <= '0;
            cnt      <= '0;
            prev     <= 1'b0;
            fail_r   <= 1'b0;
            dly_tap  <= '0;
            dly_ld   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            lane_err <= '0;
        end else begin
            dly_ld <= '0;
            case (state)
                ST_IDLE, ST_DONE: if (accept) begin
                    lane     <= '0;
                    tap      <= '0;
                    lane_err <= '0;
                    done     <= 1'b0;
                    busy     <= 1'b1;
                    dly_tap  <= '0;
                    dly_ld   <= WIDTH'(1);
                    state    <= ST_LOAD;
                end
                ST_LOAD: begin
                    cnt   <= '0;
                    state <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    cnt   <= (cnt == 32'(SETTLE_CYCLES - 1)) ? '0 : cnt + 1'b1;
                    state <= (cnt == 32'(SETTLE_CYCLES - 1)) ? ST_SAMPLE : ST_SETTLE;
                end
                ST_SAMPLE: begin
                    prev   <= cur_bit;
                    fail_r <= (cnt == '0) ? 1'b0 : (fail_r || cur_bit == prev);
                    cnt    <= cnt + 1'b1;
                    state  <= (cnt == 32'(SAMPLE_CYCLES)) ? ST_EVAL : ST_SAMPLE;
                end
                ST_EVAL: begin
                    dly_ld <= lane_1h;
                    if (tap == '1) begin
                        dly_tap <= trk_valid ? trk_centre : '0;
                        if (!trk_valid) lane_err[lane] <= 1'b1;
                        state <= ST_CENTER;
                    end else begin
                        tap     <= tap + 1'b1;
                        dly_tap <= tap + 1'b1;
                        state   <= ST_LOAD;
                    end
                end
                ST_CENTER: state <= ST_NEXT;
                ST_NEXT: if (lane == LW'(WIDTH - 1)) begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= ST_DONE;
                end else begin
                    lane    <= lane + 1'b1;
                    tap     <= '0;
                    dly_tap <= '0;
                    dly_ld  <= nxt_1h;
                    state   <= ST_LOAD;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef SSIO_ALIGN_LOCK_MON_EN
    logic [WIDTH-1:0] mon_prev;
    logic             mon_armed;

    // Toggle-rule watchdog on lanes that trained successfully; first DONE sample is the reference
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_lost <= 1'b0;
            mon_prev  <= '0;
            mon_armed <= 1'b0;
        end else if (accept) begin
            lock_lost <= 1'b0;
            mon_armed <= 1'b0;
        end else if (state == ST_DONE) begin
            mon_prev  <= data_in;
            mon_armed <= 1'b1;
            if (mon_armed && |(~(data_in ^ mon_prev) & ~lane_err)) lock_lost <= 1'b1;
        end else begin
            mon_armed <= 1'b0;
        end
    end
`else
    assign lock_lost = 1'b0;
`endif

endmodule

// File: tb/tb_ssio_sdr_in_align_ctrl.sv
// tb_ssio_sdr_in_align_ctrl: directed bench with a per-lane delay-line model driving the training pattern
module tb_ssio_sdr_in_align_ctrl;

    localparam int W = 2, TW = 3, SC = 2, SMC = 4;
    localparam int LAT = 2 * (8 * (SC + SMC + 3) + 2);

    logic          clk = 1'b0;
    logic          rst_n, start;
    logic [W-1:0]  data_in;
    logic [TW-1:0] dly_tap;
    logic [W-1:0]  dly_ld;
    logic          busy, done, lock_lost;
    logic [W-1:0]  lane_err;

    int errors = 0, checks = 0, ld_count = 0, lat, n;
    logic [7:0]    mask [2];
    logic [TW-1:0] cur_tap [2] = '{3'd0, 3'd0};
    logic [TW-1:0] last_tap [2] = '{3'd0, 3'd0};
    logic          tg = 1'b0, hold0 = 1'b0;

    ssio_sdr_in_align_ctrl #(
        .WIDTH(W), .TAP_WIDTH(TW), .SETTLE_CYCLES(SC), .SAMPLE_CYCLES(SMC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .data_in(data_in),
        .dly_tap(dly_tap), .dly_ld(dly_ld), .busy(busy), .done(done),
        .lane_err(lane_err), .lock_lost(lock_lost)
    );

    always #5 clk = ~clk;

    // Delay elements: a strobed lane latches dly_tap
    always @(posedge clk)
        for (int l = 0; l < W; l++)
            if (dly_ld[l] === 1'b1) begin
                cur_tap[l]  = dly_tap;
                last_tap[l] = dly_tap;
                ld_count++;
            end

    // Far end sends 1010...; a lane sees it cleanly only at taps inside its eye mask
    always @(negedge clk) begin
        tg = ~tg;
        for (int l = 0; l < W; l++)
            data_in[l] = (mask[l][cur_tap[l]] && !(l == 0 && hold0)) ? tg : 1'b0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic run_train(input bit mid, input string nm);
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check({nm, "_busy_rise"}, busy, 1);
        check({nm, "_done_clr"}, done, 0);
        check({nm, "_lock_clr"}, lock_lost, 0);
        lat = 0;
        while (done !== 1'b1 && lat < 1000) begin
            @(posedge clk);
            #1 lat++;
            if (mid && lat == 30) start = 1'b1;
            if (mid && lat == 32) start = 1'b0;
        end
        check({nm, "_latency"}, lat, LAT);
        check({nm, "_busy_fall"}, busy, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        mask[0] = 8'h3C;
        mask[1] = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        check("rst_dly_tap", dly_tap, 0);
        check("rst_dly_ld", dly_ld, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_lane_err", lane_err, 0);
        check("rst_lock_lost", lock_lost, 0);
        @(negedge clk) rst_n = 1'b1;

        run_train(1'b0, "s1");
        check("s1_tap0", last_tap[0], 3);
        check("s1_tap1", last_tap[1], 3);
        check("s1_lane_err", lane_err, 0);
        check("s1_done", done, 1);
        repeat (3) @(posedge clk);
        #1 check("s1_lock_idle", lock_lost, 0);
        hold0 = 1'b1;
        repeat (2) @(posedge clk);
        #1 hold0 = 1'b0;
        repeat (4) @(posedge clk);
`ifdef SSIO_ALIGN_LOCK_MON_EN
        #1 check("lock_set", lock_lost, 1);
        repeat (5) @(posedge clk);
        #1 check("lock_sticky", lock_lost, 1);
`else
        #1 check("lock_off", lock_lost, 0);
        repeat (5) @(posedge clk);
        #1 check("lock_off_late", lock_lost, 0);
`endif
        check("s1_done_held", done, 1);

        mask[0] = 8'h76;
        run_train(1'b0, "s2");
        check("s2_tap0", last_tap[0], 5);

        mask[0] = 8'h66;
        run_train(1'b0, "s3");
        check("s3_tap0_tie", last_tap[0], 1);

        mask[0] = 8'hFF;
        mask[1] = 8'h00;
        run_train(1'b0, "s4");
        check("s4_lane_err", lane_err, 2);
        check("s4_tap1", last_tap[1], 0);
        check("s4_tap0", last_tap[0], 3);
        check("s4_done", done, 1);
        repeat (5) @(posedge clk);
        #1 check("s4_lock_excl", lock_lost, 0);

        mask[0] = 8'h3C;
        mask[1] = 8'hFF;
        run_train(1'b1, "s5");
        check("s5_tap0", last_tap[0], 3);
        check("s5_tap1", last_tap[1], 3);
        check("s5_lane_err", lane_err, 0);

        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (32) @(posedge clk);
        #1 check("s6_pre_tap", dly_tap, 3);
        check("s6_pre_busy", busy, 1);
        n = ld_count;
        rst_n = 1'b0;
        #1;
        check("s6_rst_dly_tap", dly_tap, 0);
        check("s6_rst_dly_ld", dly_ld, 0);
        check("s6_rst_busy", busy, 0);
        check("s6_rst_done", done, 0);
        check("s6_rst_lane_err", lane_err, 0);
        repeat (3) @(posedge clk);
        #1 check("s6_no_load", ld_count, n);
        @(negedge clk) rst_n = 1'b1;
        run_train(1'b0, "s6");
        check("s6_tap0", last_tap[0], 3);
        check("s6_tap1", last_tap[1], 3);
        check("s6_lane_err", lane_err, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ssio_sdr_in_align_ctrl.md
# ssio_sdr_in_align_ctrl

Per-lane input-delay training sequencer for the differential source-synchronous SDR receive path. For each lane it sweeps the delay tap over its full range while the far end transmits an alternating 1010… training pattern. It finds the longest contiguous run of error-free taps and loads the centre of that run. It sits in the `output_clk` domain beside the SDR input block and drives the per-lane delay-element load interface.

## Interface
Parameters:
- `WIDTH`, 1: number of data lanes trained.
- `TAP_WIDTH`, 5: delay tap width; taps 0..2^TAP_WIDTH-1.
- `SETTLE_CYCLES`, 16: wait after each tap load before sampling (≥1).
- `SAMPLE_CYCLES`, 64: number of compared samples per tap (≥1).

Ports:
- `clk` in 1: receive clock (the SDR input block's output clock); all logic on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: level-sampled request to begin training; honoured only in IDLE or DONE.
- `data_in` in WIDTH: captured lane data from the SDR input block.
- `dly_tap` out TAP_WIDTH: tap value presented to the delay elements.
- `dly_ld` out WIDTH: one-hot, single-cycle load strobe; the lane addressed loads `dly_tap`.
- `busy` out 1: training in progress.
- `done` out 1: training complete; held until next accepted `start` or reset.
- `lane_err` out WIDTH: sticky per lane; set when the lane has no passing tap.
- `lock_lost` out 1: sticky pattern violation after `done` (see Configuration).

## Operation
- States: IDLE, LOAD, SETTLE, SAMPLE, EVAL, CENTER, NEXT, DONE.
- IDLE/DONE with `start`=1: lane←0, tap←0, run/best cleared, `lane_err`←0, `lock_lost`←0, `done`←0 → LOAD.
- LOAD: `dly_tap`=tap, `dly_ld[lane]`=1 for this cycle only → SETTLE.
- SETTLE: count SETTLE_CYCLES cycles → SAMPLE.
- SAMPLE: the first cycle captures the reference bit `data_in[lane]`. The next SAMPLE_CYCLES cycles each require `data_in[lane]` ≠ the previous sample; any equality marks the tap as failed → EVAL.
- EVAL:
  - Pass: if run_len=0 then run_start←tap; run_len++. If run_len (after increment) > best_len, then best_start←run_start and best_len←run_len.
  - Fail: run_len←0.
  - If tap = max → CENTER; otherwise tap++ → LOAD.
- CENTER:
  - best_len>0: `dly_tap` = best_start + ((best_len-1)>>1), with `dly_ld[lane]`=1.
  - best_len=0: `dly_tap`=0, `dly_ld[lane]`=1, `lane_err[lane]`←1.
  - Then → NEXT.
- NEXT: if lane=WIDTH-1 → DONE; otherwise lane++, tap←0, run/best cleared → LOAD.
- DONE: `done`=1, `busy`=0.
- Width and tie rules:
  - run_len and best_len are TAP_WIDTH+1 bits wide, so the full-range length 2^TAP_WIDTH fits.
  - The centre sum is computed at TAP_WIDTH+1 bits; the result always fits in TAP_WIDTH bits.
  - Ties: the earliest longest window wins (strict >).
- `start` while busy is ignored.
- Reset mid-operation aborts immediately. No delay load is issued, and the delay elements keep their last value.

## Timing
- Reset values: `dly_tap`=0, `dly_ld`=0, `busy`=0, `done`=0, `lane_err`=0, `lock_lost`=0, state IDLE.
- `busy` rises the cycle after `start` is accepted and falls when DONE is entered.
- Per tap: T = SETTLE_CYCLES + SAMPLE_CYCLES + 3 cycles (LOAD, SETTLE, SAMPLE incl. reference, EVAL).
- Per lane: 2^TAP_WIDTH·T + 2 cycles (CENTER, NEXT).
- `dly_ld` is always registered; `dly_tap` is stable in the same cycle as `dly_ld`.

## Configuration
- `SSIO_ALIGN_LOCK_MON_EN` defined: in DONE, every lane without `lane_err` is checked each cycle for the toggle rule. The first sample after entering DONE is the reference. Any violation sets `lock_lost`, which is cleared only by reset or an accepted `start`.
- `SSIO_ALIGN_LOCK_MON_EN` undefined: `lock_lost` is tied to 0 and no monitor logic is built.

## Structure
- Shared package `ssio_align_pkg`: state encoding constants and the centre-computation function.
- One sub-module, `ssio_align_window_tracker`: run_start, run_len, best_start and best_len, with pass/fail/clear inputs and centre and valid outputs.
- The FSM, counters and lane multiplexing stay in the top module.

## Test plan
All scenarios use WIDTH=2, TAP_WIDTH=3, SETTLE_CYCLES=2, SAMPLE_CYCLES=4, with a bench delay-line model.
- Lane0 toggles cleanly at taps 2..5 only; lane1 clean at all taps → lane0 final load tap 3, lane1 final load tap 3 (0+(8-1)>>1). `done`=1, `lane_err`=00, total latency 2·(8·9+2) cycles after the accepting edge.
- Lane0 passing taps 1..2 and 4..6 → centre 5. Lane0 passing taps 1..2 and 5..6 (tie) → centre 1.
- Lane1 held constant at all taps → `lane_err`=10, lane1 loaded with tap 0, `done`=1.
- `start` pulsed mid-sweep → ignored, sequence unchanged. `rst_n` low mid-SAMPLE → all outputs at reset values, no `dly_ld` pulse, then a clean restart succeeds.
- With `SSIO_ALIGN_LOCK_MON_EN`: after `done`, hold lane0 constant for 2 cycles → `lock_lost`=1 and sticky. Without the macro → `lock_lost` stays 0.
